// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the single-issue NPC core.
// It walks each instruction through FETCH, DECODE, optional MEM and COMMIT.
// It drives the IFU/LSU request levels and the PC-register write-enable pulses.
// It halts on ebreak and keeps cycle / retired-instruction counters.
// All outputs are registers (Moore), so no input reaches an output combinationally.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a bus-response timeout.
// When a FETCH or MEM wait reaches TIMEOUT cycles, the sequencer behaves as if
// a faulting response had been received.
module core_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ifu_rvalid,
    input  logic             i_ifu_fault,
    input  logic             i_mem_op,
    input  logic             i_ebreak,
    input  logic             i_lsu_rvalid,
    input  logic             i_lsu_fault,
    output logic             o_ifu_req,
    output logic             o_idu_valid,
    output logic             o_lsu_req,
    output logic             o_wb_en,
    output logic             o_commit,
    output logic             o_fault,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret
);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_FETCH  = 6'b000010,
        S_DECODE = 6'b000100,
        S_MEM    = 6'b001000,
        S_COMMIT = 6'b010000,
        S_HALT   = 6'b100000
    } state_t;

    state_t state;
    logic   fault_f;

    // Effective response strobes: a real rvalid, or a timeout expiry when enabled.
    logic ifu_done;
    logic ifu_flt;
    logic lsu_done;
    logic lsu_flt;

`ifdef SEQ_TIMEOUT_EN
    localparam int                WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              expire;

    // The wait expires on the TIMEOUT-th cycle without a response.
    // A real rvalid in that same cycle takes priority and keeps its own fault flag.
    always_comb begin
        expire   = (wait_cnt == WAIT_LAST);
        ifu_done = i_ifu_rvalid | expire;
        ifu_flt  = i_ifu_rvalid ? i_ifu_fault : 1'b1;
        lsu_done = i_lsu_rvalid | expire;
        lsu_flt  = i_lsu_rvalid ? i_lsu_fault : 1'b1;
    end

    // Count consecutive unanswered request cycles.
    // The count is zero whenever no wait is in progress, so every FETCH/MEM entry starts at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH && !ifu_done) || (state == S_MEM && !lsu_done)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    // Without the timeout, FETCH and MEM wait for a real response indefinitely.
    always_comb begin
        ifu_done = i_ifu_rvalid;
        ifu_flt  = i_ifu_fault;
        lsu_done = i_lsu_rvalid;
        lsu_flt  = i_lsu_fault;
    end
`endif

    // Sequencer FSM: each output is set on the transition into the state that owns it.
    // This keeps every output a plain flop.
    always_ff @(posedge i_clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // flop samples the pre-edge values; blocking here would chain the updates.
        if (i_rst) begin
            state       <= S_IDLE;
            fault_f     <= 1'b0;
            o_ifu_req   <= 1'b0;
            o_idu_valid <= 1'b0;
            o_lsu_req   <= 1'b0;
            o_wb_en     <= 1'b0;
            o_commit    <= 1'b0;
            o_fault     <= 1'b0;
            o_halted    <= 1'b0;
            o_cycle_cnt <= '0;
            o_instret   <= '0;
        end else begin
            // Pulses default low; only the transition into DECODE/COMMIT raises them.
            o_idu_valid <= 1'b0;
            o_wb_en     <= 1'b0;
            o_commit    <= 1'b0;
            o_fault     <= 1'b0;

            if (state inside {S_FETCH, S_DECODE, S_MEM, S_COMMIT}) begin
                o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    o_ifu_req <= 1'b1;
                end
                S_FETCH: begin
                    if (ifu_done) begin
                        state       <= S_DECODE;
                        fault_f     <= ifu_flt;
                        o_ifu_req   <= 1'b0;
                        o_idu_valid <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // Fetch fault outranks ebreak, which outranks a memory op.
                    if (fault_f) begin
                        state    <= S_COMMIT;
                        o_commit <= 1'b1;
                        o_fault  <= 1'b1;
                    end else if (i_ebreak) begin
                        state    <= S_HALT;
                        o_halted <= 1'b1;
                    end else if (i_mem_op) begin
                        state     <= S_MEM;
                        o_lsu_req <= 1'b1;
                    end else begin
                        state    <= S_COMMIT;
                        o_commit <= 1'b1;
                        o_wb_en  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (lsu_done) begin
                        state     <= S_COMMIT;
                        fault_f   <= lsu_flt;
                        o_lsu_req <= 1'b0;
                        o_commit  <= 1'b1;
                        o_wb_en   <= !lsu_flt;
                        o_fault   <= lsu_flt;
                    end
                end
                S_COMMIT: begin
                    state     <= S_FETCH;
                    fault_f   <= 1'b0;
                    o_ifu_req <= 1'b1;
                    o_instret <= o_instret + CNT_W'(1);
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state     <= S_IDLE;
                    fault_f   <= 1'b0;
                    o_ifu_req <= 1'b0;
                    o_lsu_req <= 1'b0;
                    o_halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
